// File: rtl/data_mem_ws.sv
// Word-organised data memory with byte/half/word/dword access, sign/zero-extended
// reads, WaitStates-cycle Req/Ack handshake and fault reporting. Optional byte-lane
// parity (InjPar/ParErr ports) is enabled by defining DMEM_PARITY_EN.
module data_mem_ws #(
  parameter int Width      = 32,
  parameter int Depth      = 128,
  parameter int WaitStates = 1
) (
  input  logic             Clk,
  input  logic             nRst,
  input  logic             Req,
  input  logic             WE,
  input  logic [1:0]       Size,
  input  logic             Signed,
  input  logic [31:0]      A,
  input  logic [Width-1:0] WD,
`ifdef DMEM_PARITY_EN
  input  logic             InjPar,
  output logic             ParErr,
`endif
  output logic             Ack,
  output logic [Width-1:0] RD,
  output logic             Fault,
  output logic             Busy
);

  localparam int NB = Width / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             signed_q, signed_d;
  logic [Width-1:0] wd_q, wd_d;
  logic             ack_q, ack_d;
  logic [Width-1:0] rd_q, rd_d;
  logic             fault_q, fault_d;
  logic             busy_q, busy_d;

  logic [Width-1:0] mem [Depth];

  // Access datapath, evaluated from the latched request
  logic [31:0]      widx_full;
  logic [AW-1:0]    widx;
  logic [LB-1:0]    lane;
  logic [LB+2:0]    lane_bits;
  logic [3:0]       nbytes;
  logic [6:0]       nbits;
  logic             addr_fault;
  logic [NB-1:0]    be;
  logic [Width-1:0] wmask;
  logic [Width-1:0] old_word;
  logic [Width-1:0] new_word;
  logic [Width-1:0] sh;
  logic [Width-1:0] keep;
  logic             sign_bit;
  logic [Width-1:0] ext;
  logic             mem_we;

`ifdef DMEM_PARITY_EN
  logic [NB-1:0]    par_mem [Depth];
  logic             inj_q, inj_d;
  logic             parerr_q, parerr_d;
  logic [NB-1:0]    old_par;
  logic [NB-1:0]    new_par;
  logic             par_bad;
`endif

  always_comb begin
    widx_full = a_q >> LB;
    widx      = widx_full[AW-1:0];
    lane      = a_q[LB-1:0];
    lane_bits = {lane, 3'b000};
    nbytes    = 4'd1 << size_q;
    nbits     = 7'd8 << size_q;

    addr_fault = (widx_full >= 32'(Depth)) ||
                 (32'(nbytes) > 32'(NB)) ||
                 ((a_q & (32'(nbytes) - 32'd1)) != 32'd0);

    be = (~({NB{1'b1}} << nbytes)) << lane;
    for (int b = 0; b < NB; b++) begin
      wmask[8*b +: 8] = {8{be[b]}};
    end

    old_word = mem[widx];
    new_word = (old_word & ~wmask) | ((wd_q << lane_bits) & wmask);

    // Read: shift addressed lanes down to bit 0, then mask and extend
    sh   = old_word >> lane_bits;
    keep = ~({Width{1'b1}} << nbits);
    case (size_q)
      2'd0:    sign_bit = sh[7];
      2'd1:    sign_bit = sh[15];
      2'd2:    sign_bit = sh[31];
      default: sign_bit = sh[Width-1];
    endcase
    ext = (sh & keep) | ((signed_q && sign_bit) ? ~keep : '0);
  end

`ifdef DMEM_PARITY_EN
  always_comb begin
    old_par = par_mem[widx];
    par_bad = 1'b0;
    for (int b = 0; b < NB; b++) begin
      new_par[b] = be[b] ? ((^new_word[8*b +: 8]) ^ inj_q) : old_par[b];
      if (be[b] && ((^old_word[8*b +: 8]) != old_par[b])) par_bad = 1'b1;
    end
  end
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    wd_d     = wd_q;
    ack_d    = 1'b0;
    rd_d     = '0;
    fault_d  = 1'b0;
    busy_d   = busy_q;
    mem_we   = 1'b0;
`ifdef DMEM_PARITY_EN
    inj_d    = inj_q;
    parerr_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (Req) begin
          a_d      = A;
          we_d     = WE;
          size_d   = Size;
          signed_d = Signed;
          wd_d     = WD;
`ifdef DMEM_PARITY_EN
          inj_d    = InjPar;
`endif
          cnt_d    = 4'(WaitStates);
          state_d  = S_WAIT;
          busy_d   = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          if (addr_fault) begin
            fault_d = 1'b1;
          end else if (we_q) begin
            mem_we = 1'b1;
          end else begin
            rd_d = ext;
`ifdef DMEM_PARITY_EN
            if (par_bad) begin
              fault_d  = 1'b1;
              parerr_d = 1'b1;
            end
`endif
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      wd_q     <= '0;
      ack_q    <= 1'b0;
      rd_q     <= '0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DMEM_PARITY_EN
      inj_q    <= 1'b0;
      parerr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wd_q     <= wd_d;
      ack_q    <= ack_d;
      rd_q     <= rd_d;
      fault_q  <= fault_d;
      busy_q   <= busy_d;
`ifdef DMEM_PARITY_EN
      inj_q    <= inj_d;
      parerr_q <= parerr_d;
`endif
    end
  end

  // NOTE: the storage array has no reset; contents must survive nRst, and resetting RAM would not map to a macro.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[widx] <= new_word;
`ifdef DMEM_PARITY_EN
      par_mem[widx] <= new_par;
`endif
    end
  end

  assign Ack   = ack_q;
  assign RD    = rd_q;
  assign Fault = fault_q;
  assign Busy  = busy_q;
`ifdef DMEM_PARITY_EN
  assign ParErr = parerr_q;
`endif

endmodule

// File: tb/tb_data_mem_ws.sv
// Self-checking bench for data_mem_ws (Width=32, Depth=128, WaitStates=2): directed
// steps plus randomized accesses checked against a byte-addressed reference model.
module tb_data_mem_ws;

  localparam int WIDTH = 32;
  localparam int DEPTH = 128;
  localparam int WS    = 2;
  localparam int NB    = WIDTH / 8;
`ifdef DMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             req;
  logic             we;
  logic [1:0]       size;
  logic             sgn;
  logic [31:0]      addr;
  logic [WIDTH-1:0] wd;
  logic             inj;
  logic             ack;
  logic [WIDTH-1:0] rd;
  logic             fault;
  logic             busy;
  logic             parerr;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_mem [0:DEPTH*NB-1];
  bit         m_bad [0:DEPTH*NB-1];

  data_mem_ws #(.Width(WIDTH), .Depth(DEPTH), .WaitStates(WS)) dut (
    .Clk    (clk),
    .nRst   (rst_n),
    .Req    (req),
    .WE     (we),
    .Size   (size),
    .Signed (sgn),
    .A      (addr),
    .WD     (wd),
`ifdef DMEM_PARITY_EN
    .InjPar (inj),
    .ParErr (parerr),
`endif
    .Ack    (ack),
    .RD     (rd),
    .Fault  (fault),
    .Busy   (busy)
  );

`ifndef DMEM_PARITY_EN
  assign parerr = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed little-endian store, rules applied directly
  function automatic void model(input bit w, input logic [1:0] sz, input bit s,
                                input logic [31:0] a, input logic [31:0] d, input bit ij,
                                output logic [31:0] exp_rd, output bit exp_f, output bit exp_p);
    int nbytes;
    int nb8;
    logic [63:0] val;
    nbytes = 1 << sz;
    nb8    = 8 * nbytes;
    exp_rd = '0;
    exp_p  = 1'b0;
    exp_f  = ((a >> 2) >= DEPTH) || (nbytes > NB) || ((a % nbytes) != 0);
    if (exp_f) return;
    if (w) begin
      for (int i = 0; i < nbytes; i++) begin
        m_mem[a+i] = d[8*i +: 8];
        m_bad[a+i] = ij && PAR;
      end
    end else begin
      val = '0;
      for (int i = 0; i < nbytes; i++) begin
        val   = val | (64'(m_mem[a+i]) << (8*i));
        exp_p = exp_p | m_bad[a+i];
      end
      if (s && val[nb8-1]) val = val | (64'hFFFF_FFFF_FFFF_FFFF << nb8);
      exp_rd = val[31:0];
      exp_f  = exp_p && PAR;
    end
  endfunction

  // Starts at #1 after an edge with the DUT idle; returns at #1 after the edge that ends Ack
  task automatic do_access(input string tag, input bit w, input logic [1:0] sz, input bit s,
                           input logic [31:0] a, input logic [31:0] d, input bit ij,
                           output logic [31:0] rd_o, output logic f_o);
    logic [31:0] exp_rd;
    bit exp_f;
    bit exp_p;
    int lat;
    logic p_o;
    model(w, sz, s, a, d, ij, exp_rd, exp_f, exp_p);
    req = 1'b1; we = w; size = sz; sgn = s; addr = a; wd = d; inj = ij;
    @(posedge clk); #1;
    req = 1'b0;
    check({tag, "/busy"}, 64'(busy), 64'(1));
    lat = 0;
    while (ack !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(WS + 1));
    rd_o = rd;
    f_o  = fault;
    p_o  = parerr;
    check({tag, "/rd"}, 64'(rd_o), 64'(exp_rd));
    check({tag, "/fault"}, 64'(f_o), 64'(exp_f));
    if (PAR) check({tag, "/parerr"}, 64'(p_o), 64'(exp_p && !w));
    @(posedge clk); #1;
    check({tag, "/ack_off"}, 64'(ack), 64'(0));
    check({tag, "/busy_off"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [31:0] r;
    logic        f;
    int          acks;
    int          first_ack;
    int          last_ack;
    int          spacing_bad;
    logic [1:0]  rsz;
    logic [31:0] ra;

    for (int i = 0; i < DEPTH*NB; i++) begin
      m_mem[i] = 8'h00;
      m_bad[i] = 1'b0;
    end
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; sgn = 1'b0;
    addr = '0; wd = '0; inj = 1'b0;

    #12;
    check("reset/ack", 64'(ack), 64'(0));
    check("reset/busy", 64'(busy), 64'(0));
    check("reset/fault", 64'(fault), 64'(0));
    check("reset/rd", 64'(rd), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known contents for the region the random phase uses
    for (int i = 0; i < 16; i++) do_access("init", 1'b1, 2'd2, 1'b0, 32'(4*i), 32'h0, 1'b0, r, f);

    // Word write/read with wait states
    do_access("t1_wr", 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 1'b0, r, f);
    do_access("t1_rd", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0, r, f);
    check("t1_rd_const", 64'(r), 64'(32'hDEADBEEF));

    // Byte lane write and extended reads
    do_access("t2_wb", 1'b1, 2'd0, 1'b0, 32'h9, 32'hA5, 1'b0, r, f);
    do_access("t2_rw", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0, r, f);
    check("t2_word_const", 64'(r), 64'(32'hDEADA5EF));
    do_access("t2_rbs", 1'b0, 2'd0, 1'b1, 32'h9, 32'h0, 1'b0, r, f);
    check("t2_sext_const", 64'(r), 64'(32'hFFFFFFA5));
    do_access("t2_rbz", 1'b0, 2'd0, 1'b0, 32'h9, 32'h0, 1'b0, r, f);
    check("t2_zext_const", 64'(r), 64'(32'h000000A5));
    do_access("t2_rhs", 1'b0, 2'd1, 1'b1, 32'hA, 32'h0, 1'b0, r, f);
    check("t2_half_const", 64'(r), 64'(32'hFFFFDEAD));

    // Fault cases
    do_access("t3_misal", 1'b0, 2'd1, 1'b0, 32'h5, 32'h0, 1'b0, r, f);
    check("t3_misal_fault", 64'(f), 64'(1));
    do_access("t3_oob", 1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, 1'b0, r, f);
    check("t3_oob_fault", 64'(f), 64'(1));
    do_access("t3_alias", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, r, f);
    check("t3_alias_const", 64'(r), 64'(0));
    do_access("t3_dword", 1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 1'b0, r, f);
    check("t3_dword_fault", 64'(f), 64'(1));

    // Req held high: one accept every WS+3 edges
    req = 1'b1; we = 1'b0; size = 2'd2; sgn = 1'b0; addr = 32'h8; inj = 1'b0;
    acks = 0; first_ack = -1; last_ack = -1; spacing_bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        if (first_ack < 0) first_ack = k;
        else if (k - last_ack != WS + 3) spacing_bad++;
        last_ack = k;
        acks++;
      end
    end
    req = 1'b0;
    check("t4_held_acks", 64'(acks), 64'(3));
    check("t4_held_first", 64'(first_ack), 64'(WS + 1));
    check("t4_held_spacing", 64'(spacing_bad), 64'(0));
    @(posedge clk); #1;
    check("t4_held_idle", 64'(busy), 64'(0));

    // Req pulses while busy are ignored
    req = 1'b1; addr = 32'h8;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
      req = (k < 4);
    end
    req = 1'b0;
    check("t4_pulse_acks", 64'(acks), 64'(1));
    check("t4_pulse_idle", 64'(busy), 64'(0));

    // Reset during WAIT discards a pending write
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h10; wd = 32'h1234;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_ack", 64'(ack), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_fault", 64'(fault), 64'(0));
    check("t5_rd", 64'(rd), 64'(0));
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_access("t5_rd_after", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, r, f);
    check("t5_rd_const", 64'(r), 64'(0));

    // Parity injection (Fault expected only when parity storage exists)
    do_access("t6_wr_inj", 1'b1, 2'd2, 1'b0, 32'h10, 32'h55AA1234, 1'b1, r, f);
    do_access("t6_rd_inj", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, r, f);
    check("t6_inj_fault", 64'(f), 64'(PAR));
    check("t6_inj_rd", 64'(r), 64'(32'h55AA1234));
    do_access("t6_wr_ok", 1'b1, 2'd2, 1'b0, 32'h10, 32'h55AA1234, 1'b0, r, f);
    do_access("t6_rd_ok", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, r, f);
    check("t6_ok_fault", 64'(f), 64'(0));

    // Randomized accesses against the model
    for (int n = 0; n < 80; n++) begin
      rsz = 2'($urandom_range(0, 3));
      ra  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rsz) - 32'd1);
      if ($urandom_range(0, 9) == 0) ra = 32'h200 + ra;
      do_access("rand", 1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra,
                $urandom, PAR && ($urandom_range(0, 5) == 0), r, f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
